blur_filter: RTL and testbench



---
 rtl/blur_filter.sv | 105 ++++++++++
 tb/tb_blur_filter.sv | 134 +++++++++++++
 2 files changed

// File: rtl/blur_filter.sv
// blur_filter: selectable 3x3 low-pass on the V channel of an HSV stream, 2-clock latency.
// Define BLUR_SAT_EN to filter the S channel with the same kernel as V.
module blur_filter #(
    parameter int LINE_W = 640
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] col,
    input  logic [10:0] x_count,
    input  logic [3:0]  filt_sel,
    input  logic [23:0] pixel_in,
    output logic [23:0] pixel_out,
    input  logic [23:0] pass_in,
    output logic [23:0] pass_thru
);
`ifdef BLUR_SAT_EN
    localparam int NC = 2;
`else
    localparam int NC = 1;
`endif
    localparam int AW = $clog2(LINE_W);
    logic [7:0]    lb0 [NC][LINE_W];
    logic [7:0]    lb1 [NC][LINE_W];
    // win[channel][row][tap]: row 0 = current line, tap 0 = newest column
    logic [7:0]    win [NC][3][3];
    logic [7:0]    tap_in [NC][3];
    logic [13:0]   gs [NC];
    logic [13:0]   bs [NC];
    logic [13:0]   hs [NC];
    logic [10:0]   bn [NC];
    logic [7:0]    filt [NC];
    logic [23:0]   pix_q;
    logic [23:0]   pass_q;
    logic [23:0]   out_n;
    logic [3:0]    sel_q;
    logic [AW-1:0] addr;
    logic          in_range;
    assign addr     = col[AW-1:0];
    assign in_range = col < 11'(LINE_W);
    always_comb begin
        for (int c = 0; c < NC; c++) begin
            tap_in[c][0] = pixel_in[8*c +: 8];
            tap_in[c][1] = in_range ? lb0[c][addr] : 8'd0;
            tap_in[c][2] = in_range ? lb1[c][addr] : 8'd0;
        end
    end
    // Line buffers are read-before-write and deliberately never reset.
    always_ff @(posedge clk) begin
        if (in_range) begin
            for (int c = 0; c < NC; c++) begin
                lb0[c][addr] <= tap_in[c][0];
                lb1[c][addr] <= tap_in[c][1];
            end
        end
    end
    always_comb begin
        for (int c = 0; c < NC; c++) begin
            gs[c] = 14'd0;
            bs[c] = 14'd0;
            for (int r = 0; r < 3; r++) begin
                for (int t = 0; t < 3; t++) begin
                    gs[c] = gs[c] + (14'(win[c][r][t]) << ((r == 1 ? 1 : 0) + (t == 1 ? 1 : 0)));
                    bs[c] = bs[c] + 14'(win[c][r][t]);
                end
            end
            hs[c]   = 14'(win[c][0][0]) + (14'(win[c][0][1]) << 1) + 14'(win[c][0][2]);
            bn[c]   = 11'((17'(bs[c]) * 17'd7 + 17'd32) >> 6);
            filt[c] = sel_q == 4'd1 ? 8'((gs[c] + 14'd8) >> 4)
                    : sel_q == 4'd2 ? (bn[c] > 11'd255 ? 8'hFF : bn[c][7:0])
                    : sel_q == 4'd3 ? 8'((hs[c] + 14'd2) >> 2)
                    : pix_q[8*c +: 8];
        end
    end
`ifdef BLUR_SAT_EN
    assign out_n = {pix_q[23:16], filt[1], filt[0]};
`else
    assign out_n = {pix_q[23:8], filt[0]};
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NC; c++)
                for (int r = 0; r < 3; r++)
                    for (int t = 0; t < 3; t++)
                        win[c][r][t] <= 8'd0;
            pix_q     <= '0;
            pass_q    <= '0;
            sel_q     <= '0;
            pixel_out <= '0;
            pass_thru <= '0;
        end else begin
            for (int c = 0; c < NC; c++) begin
                for (int r = 0; r < 3; r++) begin
                    win[c][r][0] <= tap_in[c][r];
                    win[c][r][1] <= x_count == 11'd0 ? tap_in[c][r] : win[c][r][0];
                    win[c][r][2] <= x_count == 11'd0 ? tap_in[c][r] : win[c][r][1];
                end
            end
            pix_q     <= pixel_in;
            pass_q    <= pass_in;
            sel_q     <= filt_sel;
            pixel_out <= out_n;
            pass_thru <= pass_q;
        end
    end
endmodule

// File: tb/tb_blur_filter.sv
// tb_blur_filter: directed checks of blur_filter on 8-pixel lines.
module tb_blur_filter;
    localparam int W = 8;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] col;
    logic [10:0] x_count;
    logic [3:0]  filt_sel;
    logic [23:0] pixel_in;
    logic [23:0] pixel_out;
    logic [23:0] pass_in;
    logic [23:0] pass_thru;
    int          n_cmp = 0;
    int          n_err = 0;
    bit          pend_ov = 0;
    bit          pend_pv = 0;
    logic [23:0] pend_out;
    logic [23:0] pend_pass;
    string       pend_tag;
    logic [7:0]  row_v [W];
    logic [7:0]  row_e [W];
    logic [3:0]  row_s [W];

    blur_filter #(.LINE_W(W)) dut (
        .clk(clk), .rst(rst), .col(col), .x_count(x_count), .filt_sel(filt_sel),
        .pixel_in(pixel_in), .pixel_out(pixel_out), .pass_in(pass_in), .pass_thru(pass_thru)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Output seen after this edge belongs to the pixel driven one call earlier.
    task automatic drive(input logic [23:0] p, input logic [23:0] ps, input int c, input int xc,
                         input logic [3:0] s, input bit ov, input logic [23:0] eo, input string tag);
        pixel_in = p; pass_in = ps; col = 11'(c); x_count = 11'(xc); filt_sel = s;
        @(posedge clk); #1;
        if (pend_ov) chk({pend_tag, "_pix"}, pixel_out, pend_out);
        if (pend_pv) chk({pend_tag, "_pass"}, pass_thru, pend_pass);
        pend_ov = ov; pend_pv = 1; pend_out = eo; pend_pass = ps; pend_tag = tag;
    endtask

    task automatic run_line(input logic [7:0] h, input logic [7:0] s8, input int ln, input bit ov, input string tag);
        for (int k = 0; k < W; k++)
            drive({h, s8, row_v[k]}, {8'(ln), 8'(k), 8'hA5}, k, k, row_s[k], ov,
                  {h, s8, row_e[k]}, $sformatf("%s_l%0d_c%0d", tag, ln, k));
    endtask

    task automatic fill(input logic [7:0] v, input logic [7:0] e, input logic [3:0] s);
        for (int k = 0; k < W; k++) begin
            row_v[k] = v; row_e[k] = e; row_s[k] = s;
        end
    endtask

    function automatic logic [7:0] imp(input int dr, input int k);
        int dc = k - 4;
        if (dr < -1 || dr > 1 || dc < -1 || dc > 1) return 8'd0;
        if (dr == 0 && dc == 0) return 8'd40;
        if (dr == 0 || dc == 0) return 8'd20;
        return 8'd10;
    endfunction

    initial begin
        pixel_in = 24'h5A5A5A; pass_in = 24'hC3C3C3; col = 0; x_count = 0; filt_sel = 4'd1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pix", pixel_out, 24'h0);
        chk("rst_pass", pass_thru, 24'h0);
        rst = 1'b0;
        drive(24'hFFF00F, 24'h123456, 0, 0, 4'd0, 1, 24'hFFF00F, "bypass0");
        chk("rel1_pix", pixel_out, 24'h0);
        chk("rel1_pass", pass_thru, 24'h0);
        drive(24'h0A0B0C, 24'h654321, 1, 1, 4'd0, 1, 24'h0A0B0C, "bypass1");
        drive(24'hFF00FF, 24'h00FF00, 2, 2, 4'd9, 1, 24'hFF00FF, "bypass_sel9");
        // Gaussian, box and horizontal on a flat field of 100.
        fill(8'd100, 8'd100, 4'd1);
        for (int l = 0; l < 3; l++) run_line(8'h5A, 8'hC3, l, l == 2, "gauss_flat");
        fill(8'd100, 8'd98, 4'd2);
        for (int l = 0; l < 3; l++) run_line(8'h5A, 8'hC3, l, l == 2, "box_flat");
        for (int k = 0; k < W; k++) begin
            row_s[k] = k < 4 ? 4'd2 : 4'd1;
            row_e[k] = k < 4 ? 8'd98 : 8'd100;
        end
        run_line(8'h5A, 8'hC3, 3, 1, "sel_change");
        fill(8'd100, 8'd100, 4'd3);
        for (int l = 0; l < 3; l++) run_line(8'h5A, 8'hC3, l, l == 2, "horiz_flat");
        // Gaussian impulse response.
        fill(8'd0, 8'd0, 4'd1);
        run_line(8'h12, 8'h34, 0, 0, "imp_clear");
        run_line(8'h12, 8'h34, 1, 0, "imp_clear");
        for (int l = 0; l < 3; l++) begin
            for (int k = 0; k < W; k++) begin
                row_v[k] = (l == 0 && k == 3) ? 8'd160 : 8'd0;
                row_e[k] = imp(l - 1, k);
            end
            run_line(8'h12, 8'h34, l + 2, 1, "impulse");
        end
        // Horizontal ramp with edge replication at x_count==0.
        row_v = '{8'd0, 8'd40, 8'd80, 8'd120, 8'd160, 8'd200, 8'd240, 8'd250};
        row_e = '{8'd0, 8'd10, 8'd40, 8'd80, 8'd120, 8'd160, 8'd200, 8'd233};
        for (int k = 0; k < W; k++) row_s[k] = 4'd3;
        run_line(8'h77, 8'h88, 0, 1, "ramp");
        // Reset in the middle of line 5.
        fill(8'd60, 8'd60, 4'd1);
        for (int l = 0; l < 5; l++) run_line(8'h21, 8'h43, l, l == 4, "pre_rst");
        for (int k = 0; k < 4; k++)
            drive({16'h2143, 8'd60}, {8'd5, 8'(k), 8'hA5}, k, k, 4'd1, 1, {16'h2143, 8'd60}, $sformatf("l5_c%0d", k));
        #3 rst = 1'b1;
        #1;
        chk("midrst_pix", pixel_out, 24'h0);
        chk("midrst_pass", pass_thru, 24'h0);
        pend_ov = 0; pend_pv = 0;
        @(posedge clk); #1;
        chk("midrst_hold_pix", pixel_out, 24'h0);
        chk("midrst_hold_pass", pass_thru, 24'h0);
        rst = 1'b0;
        drive({16'h2143, 8'd60}, 24'h0504A5, 4, 4, 4'd1, 0, 24'h0, "post_rst_c4");
        chk("post_rst1_pix", pixel_out, 24'h0);
        chk("post_rst1_pass", pass_thru, 24'h0);
        for (int k = 5; k < W; k++)
            drive({16'h2143, 8'd60}, {8'd5, 8'(k), 8'hA5}, k, k, 4'd1, 0, 24'h0, $sformatf("post_rst_c%0d", k));
        run_line(8'h21, 8'h43, 6, 0, "recover");
        run_line(8'h21, 8'h43, 7, 1, "recover");
        drive(24'h0, 24'h0, 0, 0, 4'd0, 0, 24'h0, "flush");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
